// File: rtl/alu_exec_stage.sv
// Execute-stage ALU with a registered valid/ready output and a one-entry skid buffer.
// Define ALU_EXEC_SLT_EN to enable Operation 4'b0111 = signed set-less-than.
module alu_exec_stage #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Operation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [TAG_W-1:0] Tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic [TAG_W-1:0] TagOut,
  output logic             Illegal
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_next;

  logic             accept;
  logic             load_main_new;
  logic             load_main_skid;
  logic             load_skid;

  logic [WIDTH-1:0] alu_res_p0;
  logic             alu_ill_p0;
  logic             alu_zero_p0;

  logic [WIDTH-1:0] main_res_p1;
  logic             main_zero_p1;
  logic [TAG_W-1:0] main_tag_p1;
  logic [WIDTH-1:0] skid_res_p1;
  logic             skid_zero_p1;
  logic [TAG_W-1:0] skid_tag_p1;
  logic             illegal_q;

  // Bit WIDTH flags an unsupported code; the result field is then zero.
  function automatic logic [WIDTH:0] alu_compute(
    input logic [3:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [WIDTH:0]          r;
    sa = a;
    sb = b;
    r  = '0;
    case (op)
      4'b0000: r[WIDTH-1:0] = a & b;
      4'b0001: r[WIDTH-1:0] = a | b;
      4'b0010: r[WIDTH-1:0] = a + b;
      4'b0110: r[WIDTH-1:0] = a - b;
`ifdef ALU_EXEC_SLT_EN
      4'b0111: r[WIDTH-1:0] = {{(WIDTH-1){1'b0}}, (sa < sb)};
`endif
      default: r[WIDTH] = 1'b1;
    endcase
    if (sa == sb) r[WIDTH:0] = r[WIDTH:0];
    return r;
  endfunction

  // Stage 0: combinational compute on the accepting cycle
  assign accept                  = in_valid && in_ready;
  assign {alu_ill_p0, alu_res_p0} = alu_compute(Operation, A, B);
  assign alu_zero_p0             = (alu_res_p0 == '0);

  always_comb begin
    state_next     = state;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          load_main_new = 1'b1;
          state_next    = ONE;
        end
      end
      ONE: begin
        if (out_ready) begin
          if (accept) load_main_new = 1'b1;
          else        state_next    = EMPTY;
        end else if (accept) begin
          load_skid  = 1'b1;
          state_next = FULL;
        end
      end
      FULL: begin
        if (out_ready) begin
          load_main_skid = 1'b1;
          state_next     = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Stage 1: main/skid capture registers and occupancy state
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= EMPTY;
      in_ready     <= 1'b0;
      illegal_q    <= 1'b0;
      main_res_p1  <= '0;
      main_zero_p1 <= 1'b0;
      main_tag_p1  <= '0;
      skid_res_p1  <= '0;
      skid_zero_p1 <= 1'b0;
      skid_tag_p1  <= '0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next != FULL);
      if (accept && alu_ill_p0) illegal_q <= 1'b1;
      if (load_main_new) begin
        main_res_p1  <= alu_res_p0;
        main_zero_p1 <= alu_zero_p0;
        main_tag_p1  <= Tag;
      end else if (load_main_skid) begin
        main_res_p1  <= skid_res_p1;
        main_zero_p1 <= skid_zero_p1;
        main_tag_p1  <= skid_tag_p1;
      end
      if (load_skid) begin
        skid_res_p1  <= alu_res_p0;
        skid_zero_p1 <= alu_zero_p0;
        skid_tag_p1  <= Tag;
      end
    end
  end

  assign out_valid = (state != EMPTY);
  assign Result    = main_res_p1;
  assign Zero      = main_zero_p1;
  assign TagOut    = main_tag_p1;
  assign Illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: random and directed operations checked against an arithmetic model.
module tb_alu_exec_stage;
  localparam int WIDTH = 64;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       Operation;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [TAG_W-1:0] Tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic [TAG_W-1:0] TagOut;
  logic             Illegal;

  alu_exec_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .Operation(Operation), .A(A), .B(B), .Tag(Tag),
    .out_valid(out_valid), .out_ready(out_ready), .Result(Result),
    .Zero(Zero), .TagOut(TagOut), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];
  logic ill_model = 1'b0;
  logic rand_ready = 1'b0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit op_legal(input logic [3:0] op);
    case (op)
      4'd0, 4'd1, 4'd2, 4'd6: return 1'b1;
`ifdef ALU_EXEC_SLT_EN
      4'd7: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t model(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] t);
    exp_t e;
    longint sa, sbv;
    sa  = a;
    sbv = b;
    case (op)
      4'd0: e.res = a & b;
      4'd1: e.res = a | b;
      4'd2: e.res = a + b;
      4'd6: e.res = a - b;
`ifdef ALU_EXEC_SLT_EN
      4'd7: e.res = (sa < sbv) ? 64'd1 : 64'd0;
`endif
      default: e.res = '0;
    endcase
    e.zero = (e.res == 0);
    e.tag  = t;
    return e;
  endfunction

  // Expected responses are recorded when the handshake is visible before the edge.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      ill_model <= 1'b0;
    end else if (in_valid && in_ready) begin
      sb.push_back(model(Operation, A, B, Tag));
      if (!op_legal(Operation)) ill_model <= 1'b1;
    end
  end

  logic             stall_q = 1'b0;
  logic [WIDTH-1:0] held_res;
  logic [TAG_W-1:0] held_tag;

  always @(negedge clk) begin
    exp_t e;
    chk("illegal_sticky", Illegal, ill_model);
    if (stall_q) begin
      chk("stall_result_stable", Result, held_res);
      chk("stall_tag_stable", TagOut, held_tag);
    end
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got Result=%0h TagOut=%0d expected no output", Result, TagOut);
      end else begin
        e = sb.pop_front();
        chk("result", Result, e.res);
        chk("zero", Zero, e.zero);
        chk("tag", TagOut, e.tag);
      end
    end
    stall_q  = !reset && out_valid && !out_ready;
    held_res = Result;
    held_tag = TagOut;
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic issue(input logic [3:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] t);
    bit acc;
    acc       = 1'b0;
    in_valid  = 1'b1;
    Operation = op;
    A         = a;
    B         = b;
    Tag       = t;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      acc = in_ready && !reset;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  logic [3:0]       ops [7] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd3, 4'd15};
  logic [WIDTH-1:0] ones;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;

  initial begin
    ones      = '1;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    Operation = '0;
    A         = '0;
    B         = '0;
    Tag       = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_result", Result, 0);
    chk("rst_zero", Zero, 0);
    chk("rst_tagout", TagOut, 0);
    chk("rst_illegal", Illegal, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    out_ready = 1'b1;
    issue(4'd2, 64'd5, 64'd7, 5'd3);
    chk("add_out_valid", out_valid, 1);
    chk("add_result", Result, 64'd12);
    chk("add_zero", Zero, 0);
    chk("add_tag", TagOut, 5'd3);
    issue(4'd6, 64'd9, 64'd9, 5'd4);
    chk("sub_eq_result", Result, 0);
    chk("sub_eq_zero", Zero, 1);
    issue(4'd6, 64'd0, 64'd1, 5'd5);
    chk("sub_wrap_result", Result, ones);
    @(posedge clk);
    #1;
    chk("idle_out_valid", out_valid, 0);

    out_ready = 1'b0;
    issue(4'd0, 64'hF0, 64'h3C, 5'd1);
    issue(4'd1, 64'hF0, 64'h0F, 5'd2);
    chk("full_in_ready", in_ready, 0);
    chk("full_head_result", Result, 64'h30);
    chk("full_head_tag", TagOut, 5'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("drain_second_result", Result, 64'hFF);
    chk("drain_second_tag", TagOut, 5'd2);
    chk("drain_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    chk("drained_out_valid", out_valid, 0);

    issue(4'd7, ones, 64'd1, 5'd6);
`ifdef ALU_EXEC_SLT_EN
    chk("slt_neg_result", Result, 64'd1);
    @(posedge clk);
    #1;
    chk("slt_no_illegal", Illegal, 0);
    issue(4'd7, 64'd1, ones, 5'd7);
    chk("slt_pos_result", Result, 64'd0);
    chk("slt_pos_zero", Zero, 1);
`else
    chk("op7_result", Result, 64'd0);
    chk("op7_zero", Zero, 1);
    chk("op7_illegal", Illegal, 1);
`endif

    issue(4'hF, 64'd123, 64'd456, 5'd8);
    chk("bad_op_result", Result, 0);
    chk("bad_op_zero", Zero, 1);
    chk("bad_op_tag", TagOut, 5'd8);
    chk("bad_op_illegal", Illegal, 1);
    issue(4'd2, 64'd1, 64'd1, 5'd9);
    chk("illegal_held", Illegal, 1);
    chk("after_bad_result", Result, 64'd2);

    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 7) == 0) ? ra : {$urandom, $urandom};
      issue(ops[$urandom_range(0, 6)], ra, rb, TAG_W'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    rand_ready = 1'b0;
    #2;
    drain();

    out_ready = 1'b0;
    issue(4'd2, 64'd1, 64'd1, 5'd10);
    issue(4'd2, 64'd2, 64'd2, 5'd11);
    chk("pre_reset_full", in_ready, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_result", Result, 0);
    chk("mid_rst_illegal", Illegal, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_release_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_stale_output", out_valid, 0);
    issue(4'd1, 64'hA0, 64'h0B, 5'd12);
    chk("post_rst_or_result", Result, 64'hAB);
    drain();
    chk("post_rst_illegal", Illegal, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
